// File: rtl/bf16_add_arbiter.sv
// bf16_add_arbiter
//   Two-requester round-robin front end for one shared, fixed-latency
//   pipelined bfloat16 adder. It issues at most one add/sub per cycle and
//   follows each operation with a tag. The tag goes down a pipe whose length
//   matches the adder latency, so every result goes back to the requester
//   that issued it.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid_N / req_ready_N  request handshake, requester N (0/1)
//   req_a_N, req_b_N          bf16 operands, requester N
//   req_sub_N                 1 = A - B, 0 = A + B
//   add_a, add_b              registered operands to the adder (B sign-adjusted)
//   add_result                adder output, ADD_LAT edges after operands
//   rsp_valid_0/1             one-cycle result pulse per requester
//   rsp_data                  shared result word, qualified by rsp_valid_*
//   idle                      no operations in flight
module bf16_add_arbiter #(
    parameter int unsigned ADD_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_0,
    output logic        req_ready_0,
    input  logic [15:0] req_a_0,
    input  logic [15:0] req_b_0,
    input  logic        req_sub_0,
    input  logic        req_valid_1,
    output logic        req_ready_1,
    input  logic [15:0] req_a_1,
    input  logic [15:0] req_b_1,
    input  logic        req_sub_1,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    input  logic [15:0] add_result,
    output logic        rsp_valid_0,
    output logic        rsp_valid_1,
    output logic [15:0] rsp_data,
    output logic        idle
);

    typedef struct packed {
        logic v;
        logic id;
    } tag_t;

    logic        last_q;
    logic [15:0] add_a_q, add_a_d;
    logic [15:0] add_b_q, add_b_d;
    logic [15:0] rsp_data_q;
    logic        rsp_valid_0_q, rsp_valid_1_q;
    logic [3:0]  count_q, count_d;
    tag_t        tag_q [ADD_LAT+1];

    logic grant_0, grant_1;
    logic hs_0, hs_1, issue, retire;

    // Round robin: a lone requester always wins; under contention the one
    // that did not issue last wins. Ready is forced low while in reset.
    always_comb begin
        grant_0 = req_valid_0 & (~req_valid_1 | last_q);
        grant_1 = req_valid_1 & (~req_valid_0 | ~last_q);
    end

    assign req_ready_0 = grant_0 & ~rst;
    assign req_ready_1 = grant_1 & ~rst;

    assign hs_0   = req_valid_0 & req_ready_0;
    assign hs_1   = req_valid_1 & req_ready_1;
    assign issue  = hs_0 | hs_1;
    // A response is retired in the cycle its pulse is presented, so idle
    // rises the cycle after the last pulse.
    assign retire = rsp_valid_0_q | rsp_valid_1_q;

    always_comb begin
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        if (hs_1) begin
            add_a_d = req_a_1;
            add_b_d = {req_b_1[15] ^ req_sub_1, req_b_1[14:0]};
        end else if (hs_0) begin
            add_a_d = req_a_0;
            add_b_d = {req_b_0[15] ^ req_sub_0, req_b_0[14:0]};
        end
    end

    always_comb begin
        count_d = count_q;
        if (issue && !retire) begin
            count_d = count_q + 4'd1;
        end else if (!issue && retire) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q        <= 1'b1;
            add_a_q       <= '0;
            add_b_q       <= '0;
            rsp_data_q    <= '0;
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
            count_q       <= '0;
            for (int unsigned i = 0; i <= ADD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
            count_q <= count_d;
            if (issue) begin
                last_q <= hs_1;
            end
            // Stage k holds the tag for operands presented k edges ago;
            // the last stage lines up with a stable add_result.
            tag_q[0] <= '{v: issue, id: hs_1};
            for (int unsigned i = 1; i <= ADD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (tag_q[ADD_LAT].v) begin
                rsp_data_q    <= add_result;
                rsp_valid_0_q <= ~tag_q[ADD_LAT].id;
                rsp_valid_1_q <= tag_q[ADD_LAT].id;
            end else begin
                rsp_valid_0_q <= 1'b0;
                rsp_valid_1_q <= 1'b0;
            end
        end
    end

    assign add_a       = add_a_q;
    assign add_b       = add_b_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_valid_0 = rsp_valid_0_q;
    assign rsp_valid_1 = rsp_valid_1_q;
    assign idle        = (count_q == 4'd0);

endmodule

// File: tb/tb_bf16_add_arbiter.sv
// Self-checking bench for bf16_add_arbiter. A behavioural bf16 adder with
// ADD_LAT pipeline stages stands in for the shared datapath. A monitor
// queues the expected result at every handshake and checks the requester
// id, the data and the arrival cycle when each response appears.
module tb_bf16_add_arbiter;

    localparam int unsigned ADD_LAT = 3;

    logic        clk, rst;
    logic        req_valid_0, req_ready_0, req_sub_0;
    logic [15:0] req_a_0, req_b_0;
    logic        req_valid_1, req_ready_1, req_sub_1;
    logic [15:0] req_a_1, req_b_1;
    logic [15:0] add_a, add_b, add_result;
    logic        rsp_valid_0, rsp_valid_1, idle;
    logic [15:0] rsp_data;

    bf16_add_arbiter #(.ADD_LAT(ADD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
        .req_a_0(req_a_0), .req_b_0(req_b_0), .req_sub_0(req_sub_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
        .req_a_1(req_a_1), .req_b_1(req_b_1), .req_sub_1(req_sub_1),
        .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_data(rsp_data), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // bf16 <-> real, normal numbers and zero only
    function automatic real bf2r(input logic [15:0] x);
        logic [10:0] e;
        if (x[14:0] == 15'd0) return 0.0;
        e = {3'b000, x[14:7]} + 11'd896;
        return $bitstoreal({x[15], e, x[6:0], 45'd0});
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] bits;
        logic [10:0] e;
        if (r == 0.0) return 16'h0000;
        bits = $realtobits(r);
        e = bits[62:52] - 11'd896;
        return {bits[63], e[7:0], bits[51:45]};
    endfunction

    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b, input logic sub);
        return r2bf(sub ? bf2r(a) - bf2r(b) : bf2r(a) + bf2r(b));
    endfunction

    function automatic logic [15:0] rnd_bf();
        logic [7:0] e;
        e = 8'($urandom_range(143, 112));
        return {1'($urandom), e, 7'($urandom)};
    endfunction

    // Stand-in adder: result stable ADD_LAT edges after operands appear
    logic [15:0] apipe [ADD_LAT];
    always @(posedge clk) begin
        apipe[0] <= r2bf(bf2r(add_a) + bf2r(add_b));
        for (int i = 1; i < int'(ADD_LAT); i++) apipe[i] <= apipe[i-1];
    end
    assign add_result = apipe[ADD_LAT-1];

    typedef struct {
        logic        id;
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t        sbq [$];
    logic [15:0] exp_pend [2];

    // Monitor: sample half a cycle away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sbq.delete();
            chk("rst_ready", {30'd0, req_ready_1, req_ready_0}, 32'd0);
            chk("rst_idle", {31'd0, idle}, 32'd1);
            chk("rst_rsp", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
        end else begin
            if (req_ready_0 && req_ready_1)
                chk("one_ready", {30'd0, req_ready_1, req_ready_0}, 32'd1);
            if (rsp_valid_0 || rsp_valid_1) begin
                if (sbq.size() == 0) begin
                    chk("spurious_rsp", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_id", {30'd0, rsp_valid_1, rsp_valid_0}, e.id ? 32'd2 : 32'd1);
                    chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end
            if (req_valid_0 && req_ready_0)
                sbq.push_back('{id: 1'b0, data: exp_pend[0], cyc: cyc + int'(ADD_LAT) + 2});
            if (req_valid_1 && req_ready_1)
                sbq.push_back('{id: 1'b1, data: exp_pend[1], cyc: cyc + int'(ADD_LAT) + 2});
        end
    end

    task automatic drive(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic [15:0] e);
        if (id == 0) begin
            req_valid_0 = 1'b1; req_a_0 = a; req_b_0 = b; req_sub_0 = sub; exp_pend[0] = e;
        end else begin
            req_valid_1 = 1'b1; req_a_1 = a; req_b_1 = b; req_sub_1 = sub; exp_pend[1] = e;
        end
    endtask

    task automatic drive_rnd(input int id);
        logic [15:0] a, b;
        logic s;
        a = rnd_bf(); b = rnd_bf(); s = 1'($urandom);
        drive(id, a, b, s, model(a, b, s));
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 40 && sbq.size() != 0; t++) @(negedge clk);
        chk("drain", sbq.size(), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        int          id;
        logic [15:0] a, b;
        logic        sub;
        logic [15:0] exp_addb, exp_rsp;
    } vec_t;
    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int np;
        bit done;

        vecs[0] = '{0, 16'h3E80, 16'h3F90, 1'b0, 16'h3F90, 16'h3FB0};
        vecs[1] = '{1, 16'h3F90, 16'h3E80, 1'b1, 16'hBE80, 16'h3F60};
        vecs[2] = '{0, 16'h4000, 16'h3F80, 1'b0, 16'h3F80, 16'h4040};
        vecs[3] = '{1, 16'h3F80, 16'h3F80, 1'b0, 16'h3F80, 16'h4000};
        vecs[4] = '{0, 16'hC000, 16'h3F80, 1'b1, 16'hBF80, 16'hC040};
        vecs[5] = '{1, 16'h4000, 16'h4000, 1'b1, 16'hC000, 16'h0000};

        rst = 1'b1;
        req_valid_0 = 1'b0; req_a_0 = '0; req_b_0 = '0; req_sub_0 = 1'b0;
        req_valid_1 = 1'b0; req_a_1 = '0; req_b_1 = '0; req_sub_1 = 1'b0;
        exp_pend[0] = '0; exp_pend[1] = '0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        @(negedge clk);
        chk("reset_add_a", {16'd0, add_a}, 32'd0);
        chk("reset_add_b", {16'd0, add_b}, 32'd0);
        chk("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("reset_idle", {31'd0, idle}, 32'd1);

        // Single operations from the vector table
        foreach (vecs[k]) begin
            @(posedge clk); #1;
            drive(vecs[k].id, vecs[k].a, vecs[k].b, vecs[k].sub, vecs[k].exp_rsp);
            @(negedge clk);
            chk("vec_ready", {30'd0, req_ready_1, req_ready_0}, vecs[k].id == 1 ? 32'd2 : 32'd1);
            @(posedge clk); #1;
            req_valid_0 = 1'b0; req_valid_1 = 1'b0;
            @(negedge clk);
            chk("vec_add_a", {16'd0, add_a}, {16'd0, vecs[k].a});
            chk("vec_add_b", {16'd0, add_b}, {16'd0, vecs[k].exp_addb});
            chk("vec_busy", {31'd0, idle}, 32'd0);
            wait_drain();
        end

        // Contention right after reset: requester 0 wins first, then alternate
        do_reset();
        drive(0, 16'h4000, 16'h3F80, 1'b0, 16'h4040);
        drive(1, 16'h3F80, 16'h3F80, 1'b0, 16'h4000);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("contend_ready", {30'd0, req_ready_1, req_ready_0}, (k % 2) ? 32'd2 : 32'd1);
            @(posedge clk); #1;
        end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        wait_drain();

        // Back-to-back streaming from requester 0
        np = 0; done = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (t < 8) drive_rnd(0); else req_valid_0 = 1'b0;
            @(negedge clk);
            if (t < 8) chk("stream_ready", {31'd0, req_ready_0}, 32'd1);
            if (np > 0 && np < 8) chk("stream_b2b", {31'd0, rsp_valid_0}, 32'd1);
            if (t > 0 && np < 8) chk("stream_busy", {31'd0, idle}, 32'd0);
            else if (np == 8 && !done) begin
                chk("stream_idle_ret", {31'd0, idle}, 32'd1);
                done = 1'b1;
            end
            if (rsp_valid_0) np++;
        end
        chk("stream_count", np, 32'd8);
        wait_drain();

        // Reset with two operations in flight
        @(posedge clk); #1;
        drive(0, 16'h4000, 16'h3F80, 1'b0, 16'h4040);
        @(posedge clk); #1;
        req_valid_0 = 1'b0;
        drive(1, 16'h3F80, 16'h3F80, 1'b0, 16'h4000);
        @(posedge clk); #1;
        req_valid_1 = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'd0, idle}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 16'h3E80, 16'h3F90, 1'b0, 16'h3FB0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_first_ready", {31'd0, req_ready_0}, 32'd1);
        @(posedge clk); #1;
        req_valid_0 = 1'b0;
        wait_drain();
        repeat (8) @(negedge clk);

        // Sparse traffic: one valid pulse every third cycle
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            drive_rnd(k % 2);
            @(negedge clk);
            chk("gap_ready", {30'd0, req_ready_1, req_ready_0}, (k % 2) ? 32'd2 : 32'd1);
            @(posedge clk); #1;
            req_valid_0 = 1'b0; req_valid_1 = 1'b0;
            @(posedge clk);
        end
        wait_drain();
        @(negedge clk);
        chk("final_idle", {31'd0, idle}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
